// File: rtl/dekatron_counter_driver_if.sv
// Command-side handshake bundle for the Dekatron counter driver.
// master: command issuer; slave: the driver (returns CmdReady).
interface dekatron_counter_driver_if #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 8
);
  logic             CmdValid;
  logic             CmdReady;
  logic [1:0]       CmdOp;
  logic [CNT_W-1:0] CmdCount;
  logic             CmdStopZero;
  logic [WIDTH-1:0] CmdData;

  modport master (
    output CmdValid, CmdOp, CmdCount,
    output CmdStopZero, CmdData,
    input  CmdReady
  );

  modport slave (
    input  CmdValid, CmdOp, CmdCount,
    input  CmdStopZero, CmdData,
    output CmdReady
  );
endinterface

// File: rtl/dekatron_counter_driver.sv
// Expands one inc/dec/load/clear command into single-cycle counter requests.
// Ports: Clk, Rst_n, cmd (slave handshake), Cnt* counter side, Done/Result/Remaining/ZeroStop/Timeout status.
module dekatron_counter_driver #(
  parameter int D_NUM          = 3,
  parameter int DEKATRON_WIDTH = 4,
  parameter int WIDTH          = D_NUM * DEKATRON_WIDTH,
  parameter int CNT_W          = 8,
  parameter int GUARD          = 2,
  parameter int TIMEOUT        = 255
) (
  input  logic             Clk,
  input  logic             Rst_n,
  dekatron_counter_driver_if.slave cmd,
  output logic             CntRequest,
  output logic             CntDec,
  output logic             CntSet,
  output logic             CntSetZero,
  output logic [WIDTH-1:0] CntIn,
  input  logic             CntReady,
  input  logic             CntZero,
  input  logic [WIDTH-1:0] CntOut,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [CNT_W-1:0] Remaining,
  output logic             ZeroStop,
  output logic             Timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_DONE
  } state_t;

  localparam logic [1:0] OP_INC  = 2'd0;
  localparam logic [1:0] OP_DEC  = 2'd1;
  localparam logic [1:0] OP_LOAD = 2'd2;
  localparam logic [1:0] OP_CLR  = 2'd3;

  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [GW-1:0] G_LAST =
    GW'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [TW-1:0] T_LAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state, state_d;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sz_q;
  logic [WIDTH-1:0] data_q;
  logic [GW-1:0]    gcnt_q;
  logic [TW-1:0]    tmo_q;
  logic             fin_zs, fin_to;
  logic             accept, to_done, active;

  assign accept  = (state == S_IDLE) && cmd.CmdValid;
  assign to_done = (state_d == S_DONE) && (state != S_DONE);
  assign active  = (state == S_ISSUE) || (state == S_GUARD);

  always_comb begin
    state_d = state;
    fin_zs  = 1'b0;
    fin_to  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd.CmdValid) begin
          // inc/dec with zero steps completes without touching the counter
          if (!cmd.CmdOp[1] && cmd.CmdCount == '0)
            state_d = S_DONE;
          else
            state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (CntReady) begin
          if (op_q == OP_DEC && sz_q && CntZero && cnt_q != '0) begin
            fin_zs  = 1'b1;
            state_d = S_DONE;
          end else if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end else if (TIMEOUT != 0 && tmo_q == T_LAST) begin
          fin_to  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_ISSUE: state_d = (GUARD == 0) ? S_WAIT : S_GUARD;
      S_GUARD: if (gcnt_q == G_LAST) state_d = S_WAIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      sz_q      <= 1'b0;
      data_q    <= '0;
      gcnt_q    <= '0;
      tmo_q     <= '0;
      Result    <= '0;
      Remaining <= '0;
      ZeroStop  <= 1'b0;
      Timeout   <= 1'b0;
    end else begin
      state  <= state_d;
      gcnt_q <= (state == S_GUARD) ? gcnt_q + 1'b1 : '0;
      if (state_d == S_WAIT && state != S_WAIT)
        tmo_q <= '0;
      else if (state == S_WAIT)
        tmo_q <= tmo_q + 1'b1;
      if (accept) begin
        op_q     <= cmd.CmdOp;
        // load/clear are a single request
        cnt_q    <= cmd.CmdOp[1] ? CNT_W'(1) : cmd.CmdCount;
        sz_q     <= cmd.CmdStopZero;
        data_q   <= cmd.CmdData;
        ZeroStop <= 1'b0;
        Timeout  <= 1'b0;
      end
      if (state == S_ISSUE)
        cnt_q <= cnt_q - 1'b1;
      if (to_done) begin
        Result    <= CntOut;
        Remaining <= accept ? '0 : cnt_q;
        ZeroStop  <= fin_zs;
        Timeout   <= fin_to;
      end
    end
  end

  assign cmd.CmdReady = (state == S_IDLE);
  assign CntRequest   = (state == S_ISSUE);
  assign CntDec       = active && (op_q == OP_DEC);
  assign CntSet       = active && (op_q == OP_LOAD);
  assign CntSetZero   = active && (op_q == OP_CLR);
  assign CntIn        = (active && op_q == OP_LOAD) ? data_q : '0;
  assign Done         = (state == S_DONE);

  logic unused_inc;
  assign unused_inc = (OP_INC == 2'd0);

endmodule

// File: tb/tb_dekatron_counter_driver.sv
// Bench for dekatron_counter_driver: behavioural BCD counter, directed table,
// hand sequences for timeout and mid-command reset, randomized commands.
module tb_dekatron_counter_driver;

  localparam logic [1:0] INC  = 2'd0;
  localparam logic [1:0] DEC  = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;
  localparam logic [1:0] CLR  = 2'd3;

  logic        Clk, Rst_n;
  logic        CntRequest, CntDec, CntSet, CntSetZero;
  logic [11:0] CntIn;
  logic        CntReady, CntZero;
  logic [11:0] CntOut;
  logic        Done;
  logic [11:0] Result;
  logic [7:0]  Remaining;
  logic        ZeroStop, Timeout;

  dekatron_counter_driver_if #(.WIDTH(12), .CNT_W(8)) cif();

  dekatron_counter_driver #(
    .D_NUM(3), .DEKATRON_WIDTH(4), .CNT_W(8),
    .GUARD(2), .TIMEOUT(10)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .cmd(cif),
    .CntRequest(CntRequest), .CntDec(CntDec),
    .CntSet(CntSet), .CntSetZero(CntSetZero),
    .CntIn(CntIn), .CntReady(CntReady),
    .CntZero(CntZero), .CntOut(CntOut),
    .Done(Done), .Result(Result),
    .Remaining(Remaining), .ZeroStop(ZeroStop),
    .Timeout(Timeout)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int nerr = 0;
  int nchk = 0;

  function automatic void chk(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [11:0] to_bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // behavioural counter: value 0..999, busy for lat cycles per request
  int cval = 0;
  int busy = 0;
  int pend = 0;
  int lat = 3;
  bit stuck = 1'b0;
  bit preset_en = 1'b0;
  int preset_val = 0;

  always @(negedge Clk) begin
    if (preset_en) begin
      cval = preset_val;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) cval = pend;
    end else if (CntRequest) begin
      if (CntSet) pend = from_bcd(CntIn);
      else if (CntSetZero) pend = 0;
      else if (CntDec) pend = (cval + 999) % 1000;
      else pend = (cval + 1) % 1000;
      busy = lat;
    end
  end

  assign CntReady = (busy == 0) && !stuck;
  assign CntOut   = to_bcd(cval);
  assign CntZero  = (cval == 0);

  // request monitor: pulse shape and qualifier stability through guard
  int nreq = 0;
  int hold = 0;
  bit prev_req = 1'b0;
  int exp_qual = 0;
  int exp_in = 0;

  always @(negedge Clk) begin
    if (!Rst_n) begin
      hold = 0;
      prev_req = 1'b0;
    end else begin
      if (CntRequest) begin
        nreq++;
        chk("req_gap", int'(prev_req), 0);
        chk("req_qual", int'({CntDec, CntSet, CntSetZero}), exp_qual);
        chk("req_in", int'(CntIn), exp_in);
        hold = 2;
      end else if (hold > 0) begin
        chk("guard_qual", int'({CntDec, CntSet, CntSetZero}), exp_qual);
        chk("guard_in", int'(CntIn), exp_in);
        hold--;
      end
      prev_req = CntRequest;
    end
  end

  task automatic preset(input int v);
    @(posedge Clk); #1;
    preset_val = v;
    preset_en = 1'b1;
    @(posedge Clk); #1;
    preset_en = 1'b0;
  endtask

  task automatic do_cmd(
    input string nm, input logic [1:0] op, input int n,
    input bit sz, input logic [11:0] d, input int start,
    input int e_res, input int e_rem, input bit e_zs,
    input bit e_to, input int e_nreq, input int e_cyc
  );
    int base, cyc;
    bit got;
    preset(start);
    unique case (op)
      INC:  exp_qual = 3'b000;
      DEC:  exp_qual = 3'b100;
      LOAD: exp_qual = 3'b010;
      default: exp_qual = 3'b001;
    endcase
    exp_in = (op == LOAD) ? int'(d) : 0;
    @(negedge Clk);
    chk({nm, "_cmdready"}, int'(cif.CmdReady), 1);
    chk({nm, "_idle_qual"}, int'({CntDec, CntSet, CntSetZero, CntIn}), 0);
    cif.CmdValid = 1'b1;
    cif.CmdOp = op;
    cif.CmdCount = 8'(n);
    cif.CmdStopZero = sz;
    cif.CmdData = d;
    base = nreq;
    @(posedge Clk); #1;
    cif.CmdValid = 1'b0;
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge Clk);
      cyc++;
      if (Done) got = 1'b1;
    end
    chk({nm, "_done_seen"}, int'(got), 1);
    if (got) begin
      chk({nm, "_result"}, int'(Result), e_res);
      chk({nm, "_remaining"}, int'(Remaining), e_rem);
      chk({nm, "_zerostop"}, int'(ZeroStop), int'(e_zs));
      chk({nm, "_timeout"}, int'(Timeout), int'(e_to));
      chk({nm, "_nreq"}, nreq - base, e_nreq);
      if (e_cyc >= 0) chk({nm, "_latency"}, cyc, e_cyc);
      @(negedge Clk);
      chk({nm, "_done_pulse"}, int'(Done), 0);
    end
  endtask

  typedef struct {
    string      nm;
    logic [1:0] op;
    int         n;
    bit         sz;
    logic [11:0] d;
    int         start;
    int         l;
    logic [11:0] e_res;
    int         e_rem;
    bit         e_zs;
    int         e_nreq;
    int         e_cyc;
  } vec_t;

  vec_t vt[7];

  initial begin
    int base;
    bit got;
    logic [1:0] op;
    int n, v, dv, steps, res, rem;
    bit sz, zs;

    vt[0] = '{"inc3",   INC,  3, 0, 12'h000, 0,   3, 12'h003, 0, 0, 3, -1};
    vt[1] = '{"decsz",  DEC,  5, 1, 12'h000, 2,   3, 12'h000, 3, 1, 2, -1};
    vt[2] = '{"load",   LOAD, 9, 0, 12'h473, 123, 3, 12'h473, 0, 0, 1, -1};
    vt[3] = '{"clear",  CLR,  0, 0, 12'h999, 555, 2, 12'h000, 0, 0, 1, -1};
    vt[4] = '{"inc0",   INC,  0, 0, 12'h000, 7,   3, 12'h007, 0, 0, 0, 1};
    vt[5] = '{"decwrap",DEC,  2, 0, 12'h000, 0,   1, 12'h998, 0, 0, 2, -1};
    vt[6] = '{"incwrap",INC,  1, 0, 12'h000, 999, 4, 12'h000, 0, 0, 1, -1};

    Rst_n = 1'b0;
    cif.CmdValid = 1'b0;
    cif.CmdOp = 2'd0;
    cif.CmdCount = 8'd0;
    cif.CmdStopZero = 1'b0;
    cif.CmdData = 12'd0;
    repeat (3) @(negedge Clk);
    chk("rst_cmdready", int'(cif.CmdReady), 1);
    chk("rst_request", int'(CntRequest), 0);
    chk("rst_quals", int'({CntDec, CntSet, CntSetZero, CntIn}), 0);
    chk("rst_status", int'({Done, Result, Remaining, ZeroStop, Timeout}), 0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    foreach (vt[i]) begin
      lat = vt[i].l;
      do_cmd(vt[i].nm, vt[i].op, vt[i].n, vt[i].sz, vt[i].d,
             vt[i].start, int'(vt[i].e_res), vt[i].e_rem,
             vt[i].e_zs, 1'b0, vt[i].e_nreq, vt[i].e_cyc);
    end

    // counter never ready: 10 WAIT cycles then Done in the 11th
    stuck = 1'b1;
    do_cmd("tmo", INC, 4, 0, 12'h000, 0, 0, 4, 0, 1, 0, 11);
    stuck = 1'b0;
    lat = 2;
    do_cmd("after_tmo", INC, 1, 0, 12'h000, 41, 12'h042, 0, 0, 0, 1, -1);

    // reset in the middle of the second of four inc requests
    lat = 3;
    preset(0);
    exp_qual = 0;
    exp_in = 0;
    @(negedge Clk);
    cif.CmdValid = 1'b1;
    cif.CmdOp = INC;
    cif.CmdCount = 8'd4;
    cif.CmdStopZero = 1'b0;
    base = nreq;
    @(posedge Clk); #1;
    cif.CmdValid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge Clk); #1;
      if (nreq - base >= 2) got = 1'b1;
    end
    chk("rst_mid_second_req", int'(got), 1);
    Rst_n = 1'b0;
    #1;
    chk("rst_mid_request", int'(CntRequest), 0);
    chk("rst_mid_cmdready", int'(cif.CmdReady), 1);
    chk("rst_mid_status", int'({Done, Result, Remaining}), 0);
    @(negedge Clk); #1;
    Rst_n = 1'b1;
    repeat (20) @(negedge Clk);
    chk("rst_mid_no_more_req", nreq - base, 2);
    do_cmd("rst_inc0", INC, 0, 0, 12'h000, 5, 12'h005, 0, 0, 0, 0, 1);

    // randomized commands against the arithmetic reference
    for (int t = 0; t < 30; t++) begin
      op = 2'($urandom_range(0, 3));
      n = $urandom_range(0, 6);
      sz = 1'($urandom_range(0, 1));
      v = (op == DEC && sz) ? $urandom_range(0, 8) : $urandom_range(0, 999);
      dv = $urandom_range(0, 999);
      lat = $urandom_range(1, 5);
      zs = 1'b0;
      rem = 0;
      unique case (op)
        INC: begin
          steps = n;
          res = (v + n) % 1000;
        end
        DEC: begin
          steps = (sz && v < n) ? v : n;
          zs = sz && (v < n);
          rem = n - steps;
          res = (v - steps + 1000) % 1000;
        end
        LOAD: begin
          steps = 1;
          res = dv;
        end
        default: begin
          steps = 1;
          res = 0;
        end
      endcase
      do_cmd("rnd", op, n, sz, to_bcd(dv), v, int'(to_bcd(res)),
             rem, zs, 1'b0, steps,
             (!op[1] && n == 0) ? 1 : -1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dekatron_counter_driver.md
# dekatron_counter_driver

Command-side initiator for the Dekatron counter request/ready handshake. It accepts one high-level command (step N times up or down, load a value, clear), expands it into a sequence of single-cycle counter requests, and waits for the counter's Ready between requests. It sits between instruction-level control (IP/AP/loop logic) and a Dekatron counter instance, and reports completion, final counter value, early zero-stop and handshake timeout.

## Interface
Parameters:
- D_NUM, 3, number of dekatron digits on the driven counter
- DEKATRON_WIDTH, 4, bits per digit (BCD)
- WIDTH, D_NUM*DEKATRON_WIDTH, counter data width
- CNT_W, 8, width of step count
- GUARD, 2, cycles after Request falls during which CntReady is ignored
- TIMEOUT, 255, max cycles waiting for CntReady before error; 0 disables

Ports:
- Clk  in  1  system clock (same clock as the counter)
- Rst_n  in  1  reset, asynchronous, active-low
- CmdValid  in  1  command offered
- CmdReady  out  1  driver idle, command accepted when CmdValid&CmdReady
- CmdOp  in  2  00 inc, 01 dec, 10 load, 11 clear
- CmdCount  in  CNT_W  step count for inc/dec; ignored for load/clear
- CmdStopZero  in  1  dec only: stop early once CntZero=1
- CmdData  in  WIDTH  load value
- CntRequest  out  1  request to counter
- CntDec  out  1  direction to counter
- CntSet  out  1  load strobe qualifier
- CntSetZero  out  1  clear qualifier
- CntIn  out  WIDTH  load data to counter
- CntReady  in  1  counter ready
- CntZero  in  1  counter at zero
- CntOut  in  WIDTH  counter value
- Done  out  1  one-cycle completion pulse
- Result  out  WIDTH  CntOut captured at completion
- Remaining  out  CNT_W  steps not executed (nonzero only on zero-stop or timeout)
- ZeroStop  out  1  last command ended by CmdStopZero
- Timeout  out  1  last command ended by timeout

## Operation
- States: IDLE, ISSUE, GUARD, WAIT, DONE. Reset -> IDLE.
- IDLE: CmdReady=1. On accept, latch op, count, stopzero, data into registers; clear ZeroStop/Timeout. If op is inc/dec with count 0 -> DONE directly (no request). Otherwise -> WAIT (must first see CntReady before the first request).
- WAIT: CmdReady=0. If CntReady=1 -> ISSUE. Timeout counter increments each cycle in WAIT; reaching TIMEOUT (if nonzero) -> DONE with Timeout=1.
- ISSUE: CntRequest=1 for exactly one cycle with CntDec/CntSet/CntSetZero/CntIn valid and unchanged. inc: Dec=0; dec: Dec=1; load: Set=1, CntIn=latched data; clear: SetZero=1. Decrement remaining count for inc/dec; load/clear count as one request. -> GUARD.
- GUARD: CntRequest=0, hold qualifiers, ignore CntReady for GUARD cycles, then -> WAIT if requests remain or zero-stop check pending, else wait for CntReady and go DONE.
- Zero-stop: dec with CmdStopZero; after each completed step (CntReady=1 in WAIT), if CntZero=1 and remaining>0 -> DONE with ZeroStop=1.
- DONE: Done=1 one cycle, Result<=CntOut, Remaining<=latched remaining count -> IDLE.
- Qualifiers CntDec/CntSet/CntSetZero/CntIn held stable from ISSUE through end of GUARD; 0 in IDLE.
- CmdValid while busy is ignored (no queueing).

## Timing
- Reset values: CmdReady=1, CntRequest=0, CntDec=0, CntSet=0, CntSetZero=0, CntIn=0, Done=0, Result=0, Remaining=0, ZeroStop=0, Timeout=0.
- Minimum per step with counter immediately ready: WAIT 1 + ISSUE 1 + GUARD cycles; N steps take at least N*(2+GUARD)+2 cycles from accept to Done.
- CntRequest never high on two consecutive cycles; always has a falling edge between requests.
- Count 0 inc/dec: Done on the cycle after accept.
- Timeout counter cleared on entry to WAIT.
- Rst_n asserted mid-command: all outputs return to reset values asynchronously; no further request issued; latched command discarded.
- CntReady dropping in WAIT (counter busy elsewhere) keeps driver in WAIT.

## Test plan
- Counter model at 0, inc count 3, Ready 3 cycles after each request -> exactly 3 CntRequest pulses with CntDec=0, Done with Result=003, Remaining=0.
- Counter at 002, dec count 5, CmdStopZero=1 -> 2 requests, Done with ZeroStop=1, Result=000, Remaining=3.
- Load CmdData=0x473 -> one request with CntSet=1, CntIn=0x473 stable through GUARD; Done with Result=473.
- Clear from 0x555 -> one request with CntSetZero=1, Result=000.
- CntReady stuck low, TIMEOUT=10, inc count 4 -> no request, Done after 10 WAIT cycles, Timeout=1, Remaining=4.
- Rst_n pulsed during second of 4 inc steps -> CntRequest=0 immediately, CmdReady=1, no further requests; inc count 0 afterwards -> Done next cycle, no request.
